fetch_queue: RTL

- Instruction-fetch stage directly downstream of the program counter.
- Takes the current PC, issues instruction-memory reads, and buffers returned instructions with their PC in a small in-order queue.
- Presents buffered instructions to decode through a valid/ready handshake.
- Drives the PC's advance and jump controls: the PC only increments when a fetch is actually issued, and redirects are flushed cleanly.

---
 rtl/fetch_queue.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues imem reads from the PC and buffers {instr, pc} in an in-order queue for decode.
// Optional FETCH_PERF_EN adds perf_fetches / perf_flushes counters. state_dbg exposes the FSM state.
module fetch_queue #(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_advance,
  output logic        pc_jump_en,
  output logic [31:0] pc_jump_out,
  input  logic        jump_req,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_flushes,
`endif
  output logic [1:0]  state_dbg
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_HALTED = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            inflight_v_q, inflight_v_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;
  logic [31:0]     instr_mem_q [DEPTH];
  logic [31:0]     pc_mem_q    [DEPTH];

  logic            redirect, issue, push, pop;
  logic [CW:0]     occupancy;

  assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_v_q);
  assign redirect  = jump_req && (state_q != S_BOOT);
  // Occupancy uses registered values only, so a same-cycle pop never frees a slot early.
  assign issue     = (state_q == S_RUN) && !halt && !jump_req && (occupancy < (CW+1)'(DEPTH));
  assign push      = inflight_v_q && !redirect;
  assign pop       = dec_valid && dec_ready && !redirect;

  assign dec_valid = (count_q != '0);
  assign dec_instr = dec_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign dec_pc    = dec_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
  assign imem_addr = pc_in;
  assign imem_req  = issue;
  assign pc_advance = issue;
  assign state_dbg = state_q;

  always_comb begin
    state_d       = state_q;
    pc_jump_en    = 1'b0;
    pc_jump_out   = jump_target;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inflight_v_d  = issue;
    inflight_pc_d = issue ? pc_in : inflight_pc_q;

    case (state_q)
      S_BOOT: begin
        pc_jump_en  = 1'b1;
        pc_jump_out = RESET_VECTOR;
        state_d     = S_RUN;
      end
      S_RUN:    if (!jump_req && halt)  state_d = S_HALTED;
      S_HALTED: if (!jump_req && !halt) state_d = S_RUN;
      default:  state_d = S_BOOT;
    endcase

    if (redirect) pc_jump_en = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A redirect discards the queue and whatever response lands next cycle.
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_BOOT;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assert property (@(posedge clock) disable iff (reset) !(push && (count_q == CW'(DEPTH))));

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetches_q, perf_fetches_d, perf_flushes_q, perf_flushes_d;
  logic        flush_hit;

  assign flush_hit    = redirect && ((count_q != '0) || inflight_v_q);
  assign perf_fetches = perf_fetches_q;
  assign perf_flushes = perf_flushes_q;

  always_comb begin
    perf_fetches_d = perf_fetches_q;
    perf_flushes_d = perf_flushes_q;
    if (issue && (perf_fetches_q != 32'hFFFF_FFFF))     perf_fetches_d = perf_fetches_q + 32'd1;
    if (flush_hit && (perf_flushes_q != 32'hFFFF_FFFF)) perf_flushes_d = perf_flushes_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetches_q <= 32'h0;
      perf_flushes_q <= 32'h0;
    end else begin
      perf_fetches_q <= perf_fetches_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end
`endif

endmodule
